// File: rtl/lcd_bus_monitor.sv
// Passive monitor for an HD44780-style character-LCD bus: synchronizes the bus,
// decodes accepted writes and mirrors the controller's 2x16 display buffer and mode bits.
`timescale 1ns/1ps
module lcd_bus_monitor #(
  parameter int unsigned CLEAR_CYCLES = 40,
  parameter int unsigned BUSY_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic [6:0] ddram_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       two_line,
  output logic       font5x10,
  output logic       bus8,
  output logic       busy,
  output logic       cmd_stb,
  output logic [7:0] cmd_byte,
  output logic       overrun
);

  localparam int unsigned DW      = 8;
  localparam int unsigned AW      = 7;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned SW      = DW + 3;
  localparam int unsigned MAXCYC  = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CW      = $clog2(MAXCYC + 1);
  localparam logic [DW-1:0] SPACE = 8'h20;

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, BUSY} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic            e_prev_q, e_prev_d;
  logic [DW-1:0]   buf_q [DEPTH];
  logic [DW-1:0]   buf_d [DEPTH];
  logic [DW-1:0]   rd_char_q, rd_char_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic            inc_q, inc_d, shift_q, shift_d;
  logic            two_line_q, two_line_d, font_q, font_d, bus8_q, bus8_d;
  logic            busy_q, busy_d, cmd_stb_q, cmd_stb_d, overrun_q, overrun_d;
  logic [DW-1:0]   cmd_byte_q, cmd_byte_d, cmd_dat_q, cmd_dat_d;
  logic            cmd_rs_q, cmd_rs_d;
  logic [CW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [4:0]      clr_idx_q, clr_idx_d;

  logic            s_e, s_rs, s_rw, strobe_c;
  logic [DW-1:0]   s_dat;

  assign {s_e, s_rs, s_rw, s_dat} = sync2_q;
  assign strobe_c = e_prev_q & ~s_e;

  // Address counter step with the two-line DDRAM wrap points.
  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      step_addr = 7'h40;
      else if (a == 7'h67) step_addr = 7'h00;
      else                 step_addr = a + 7'd1;
    end else begin
      if (a == 7'h00)      step_addr = 7'h67;
      else if (a == 7'h40) step_addr = 7'h27;
      else                 step_addr = a - 7'd1;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    sync1_d    = {lcd_e, lcd_rs, lcd_rw, lcd_data};
    sync2_d    = sync1_q;
    e_prev_d   = s_e;
    buf_d      = buf_q;
    rd_char_d  = buf_q[rd_idx];
    addr_d     = addr_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    inc_d      = inc_q;
    shift_d    = shift_q;
    two_line_d = two_line_q;
    font_d     = font_q;
    bus8_d     = bus8_q;
    cmd_stb_d  = 1'b0;
    cmd_byte_d = cmd_byte_q;
    overrun_d  = overrun_q;
    cmd_dat_d  = cmd_dat_q;
    cmd_rs_d   = cmd_rs_q;
    clr_idx_d  = clr_idx_q;
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - CW'(1) : busy_cnt_q;

    case (state_q)
      EXEC: begin
        if (cmd_rs_q) begin
          if (addr_q[6:4] == 3'b000 || addr_q[6:4] == 3'b100)
            buf_d[{addr_q[6], addr_q[3:0]}] = cmd_dat_q;
          addr_d = step_addr(addr_q, inc_q);
        end else begin
          // Instruction class is chosen by the highest set bit.
          casez (cmd_dat_q)
            8'b1???????: addr_d = cmd_dat_q[6:0];
            8'b001?????: begin
              bus8_d     = cmd_dat_q[4];
              two_line_d = cmd_dat_q[3];
              font_d     = cmd_dat_q[2];
            end
            8'b00001???: begin
              disp_d   = cmd_dat_q[2];
              cursor_d = cmd_dat_q[1];
              blink_d  = cmd_dat_q[0];
            end
            8'b000001??: begin
              inc_d   = cmd_dat_q[1];
              shift_d = cmd_dat_q[0];
            end
            8'b0000001?: addr_d = '0;
            8'b00000001: begin
              addr_d = '0;
              inc_d  = 1'b1;
            end
            default: ;
          endcase
        end
        if (!cmd_rs_q && cmd_dat_q == 8'h01) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else begin
          state_d = (busy_cnt_q <= CW'(1)) ? IDLE : BUSY;
        end
      end
      CLEAR: begin
        buf_d[clr_idx_q] = SPACE;
        clr_idx_d        = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) state_d = BUSY;
      end
      BUSY: if (busy_cnt_q <= CW'(1)) state_d = IDLE;
      default: ;
    endcase

    // Write strobes are accepted only when not busy; a null instruction is ignored.
    if (strobe_c && !s_rw && (s_rs || s_dat != '0)) begin
      if (busy_q) begin
        overrun_d = 1'b1;
      end else begin
        state_d    = EXEC;
        cmd_rs_d   = s_rs;
        cmd_dat_d  = s_dat;
        busy_cnt_d = (!s_rs && s_dat == 8'h01) ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
        if (!s_rs) begin
          cmd_stb_d  = 1'b1;
          cmd_byte_d = s_dat;
        end
      end
    end

    busy_d = (busy_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      e_prev_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= SPACE;
      rd_char_q  <= '0;
      addr_q     <= '0;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      inc_q      <= 1'b1;
      shift_q    <= 1'b0;
      two_line_q <= 1'b0;
      font_q     <= 1'b0;
      bus8_q     <= 1'b0;
      busy_q     <= 1'b0;
      cmd_stb_q  <= 1'b0;
      cmd_byte_q <= '0;
      overrun_q  <= 1'b0;
      cmd_dat_q  <= '0;
      cmd_rs_q   <= 1'b0;
      busy_cnt_q <= '0;
      clr_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      e_prev_q   <= e_prev_d;
      buf_q      <= buf_d;
      rd_char_q  <= rd_char_d;
      addr_q     <= addr_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      inc_q      <= inc_d;
      shift_q    <= shift_d;
      two_line_q <= two_line_d;
      font_q     <= font_d;
      bus8_q     <= bus8_d;
      busy_q     <= busy_d;
      cmd_stb_q  <= cmd_stb_d;
      cmd_byte_q <= cmd_byte_d;
      overrun_q  <= overrun_d;
      cmd_dat_q  <= cmd_dat_d;
      cmd_rs_q   <= cmd_rs_d;
      busy_cnt_q <= busy_cnt_d;
      clr_idx_q  <= clr_idx_d;
    end
  end

  assign rd_char    = rd_char_q;
  assign ddram_addr = addr_q;
  assign disp_on    = disp_q;
  assign cursor_on  = cursor_q;
  assign blink_on   = blink_q;
  assign inc_mode   = inc_q;
  assign shift_mode = shift_q;
  assign two_line   = two_line_q;
  assign font5x10   = font_q;
  assign bus8       = bus8_q;
  assign busy       = busy_q;
  assign cmd_stb    = cmd_stb_q;
  assign cmd_byte   = cmd_byte_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: table of bus strobes plus hand sequences
// for clear, overrun, decrement mode and reset abort.
`timescale 1ns/1ps
module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       resetn;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_idx;
  logic [7:0] rd_char, cmd_byte;
  logic [6:0] ddram_addr;
  logic       disp_on, cursor_on, blink_on, inc_mode, shift_mode;
  logic       two_line, font5x10, bus8, busy, cmd_stb, overrun;

  lcd_bus_monitor #(.CLEAR_CYCLES(40), .BUSY_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_idx(rd_idx), .rd_char(rd_char), .ddram_addr(ddram_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .inc_mode(inc_mode),
    .shift_mode(shift_mode), .two_line(two_line), .font5x10(font5x10), .bus8(bus8),
    .busy(busy), .cmd_stb(cmd_stb), .cmd_byte(cmd_byte), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    int         busy_n;
    int         stb_n;
    logic [6:0] addr;
  } vec_t;

  vec_t vecs [15];
  int   checks = 0;
  int   failures = 0;
  int   busy_seen, stb_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One full E pulse; busy and cmd_stb are counted over a window after the fall.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int win);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    busy_seen = 0; stb_seen = 0;
    repeat (win) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (cmd_stb) stb_seen++;
    end
  endtask

  task automatic read_chk(input logic [4:0] idx, input logic [7:0] req, input string name);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
    check(name, 32'(rd_char), 32'(req));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'h38, 2, 1, 7'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h06, 2, 1, 7'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h0C, 2, 1, 7'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h80, 2, 1, 7'h00};
    vecs[4]  = '{1'b1, 1'b0, 8'h55, 2, 0, 7'h01};
    vecs[5]  = '{1'b1, 1'b0, 8'h50, 2, 0, 7'h02};
    vecs[6]  = '{1'b0, 1'b0, 8'hC0, 2, 1, 7'h40};
    vecs[7]  = '{1'b1, 1'b0, 8'h44, 2, 0, 7'h41};
    vecs[8]  = '{1'b0, 1'b0, 8'hA7, 2, 1, 7'h27};
    vecs[9]  = '{1'b1, 1'b0, 8'h41, 2, 0, 7'h40};
    vecs[10] = '{1'b0, 1'b1, 8'h80, 0, 0, 7'h40};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 0, 0, 7'h40};
    vecs[12] = '{1'b0, 1'b0, 8'h10, 2, 1, 7'h40};
    vecs[13] = '{1'b0, 1'b0, 8'hE7, 2, 1, 7'h67};
    vecs[14] = '{1'b1, 1'b0, 8'h5A, 2, 0, 7'h00};

    resetn = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(ddram_addr), 32'd0);
    check("rst_inc", 32'(inc_mode), 32'd1);
    check("rst_cmd_byte", 32'(cmd_byte), 32'd0);
    check("rst_flags", 32'({disp_on, cursor_on, blink_on, shift_mode, two_line, font5x10, bus8, overrun}), 32'd0);
    resetn = 1'b1;
    read_chk(5'd9, 8'h20, "rst_buf9");

    for (int i = 0; i < 15; i++) begin
      strobe(vecs[i].rs, vecs[i].rw, vecs[i].d, 12);
      check($sformatf("vec%0d_busy", i), 32'(busy_seen), 32'(vecs[i].busy_n));
      check($sformatf("vec%0d_stb", i), 32'(stb_seen), 32'(vecs[i].stb_n));
      check($sformatf("vec%0d_addr", i), 32'(ddram_addr), 32'(vecs[i].addr));
    end
    check("init_bus8_n", 32'({bus8, two_line, font5x10}), 32'b110);
    check("init_dcb", 32'({disp_on, cursor_on, blink_on}), 32'b100);
    check("init_inc", 32'(inc_mode), 32'd1);
    check("cmd_byte_last", 32'(cmd_byte), 32'hE7);
    check("no_overrun", 32'(overrun), 32'd0);
    read_chk(5'd0, 8'h55, "buf0_U");
    read_chk(5'd1, 8'h50, "buf1_P");
    read_chk(5'd16, 8'h44, "buf16_D");
    read_chk(5'd2, 8'h20, "buf2_blank");
    read_chk(5'd17, 8'h20, "buf17_blank");

    // Clear display: 40 busy cycles, everything back to spaces.
    strobe(1'b0, 1'b0, 8'h01, 60);
    check("clr_busy", 32'(busy_seen), 32'd40);
    check("clr_stb", 32'(stb_seen), 32'd1);
    check("clr_addr", 32'(ddram_addr), 32'd0);
    for (int i = 0; i < 32; i++) read_chk(5'(i), 8'h20, $sformatf("clr_buf%0d", i));

    // Second strobe right behind a clear is dropped and flagged.
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    lcd_rs = 1'b1; lcd_data = 8'h41; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_busy_during", 32'(busy), 32'd1);
    lcd_e = 1'b0;
    repeat (60) @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_busy_done", 32'(busy), 32'd0);
    check("ovr_addr", 32'(ddram_addr), 32'd0);
    read_chk(5'd0, 8'h20, "ovr_buf0");

    // Decrement mode and wrap-around.
    strobe(1'b0, 1'b0, 8'h04, 12);
    check("dec_inc", 32'({inc_mode, shift_mode}), 32'b00);
    strobe(1'b0, 1'b0, 8'h80, 12);
    strobe(1'b1, 1'b0, 8'h58, 12);
    check("dec_addr_wrap0", 32'(ddram_addr), 32'h67);
    read_chk(5'd0, 8'h58, "dec_buf0");
    strobe(1'b0, 1'b0, 8'hC0, 12);
    strobe(1'b1, 1'b0, 8'h31, 12);
    check("dec_addr_wrap40", 32'(ddram_addr), 32'h27);
    read_chk(5'd16, 8'h31, "dec_buf16");
    strobe(1'b1, 1'b1, 8'h99, 12);
    check("rd_busy", 32'(busy_seen), 32'd0);
    check("rd_addr", 32'(ddram_addr), 32'h27);
    read_chk(5'd16, 8'h31, "rd_buf16");
    strobe(1'b0, 1'b0, 8'h05, 12);
    check("shift_set", 32'({inc_mode, shift_mode}), 32'b01);

    // Reset in the middle of a clear aborts it.
    strobe(1'b0, 1'b0, 8'h0F, 12);
    check("dcb_all", 32'({disp_on, cursor_on, blink_on}), 32'b111);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    resetn = 1'b0;
    #2;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flags", 32'({disp_on, cursor_on, blink_on, shift_mode, overrun, inc_mode}), 32'b000001);
    check("abort_cmd_byte", 32'(cmd_byte), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    strobe(1'b0, 1'b0, 8'h80, 12);
    check("post_rst_stb", 32'(stb_seen), 32'd1);
    strobe(1'b1, 1'b0, 8'h33, 12);
    check("post_rst_busy", 32'(busy_seen), 32'd2);
    check("post_rst_addr", 32'(ddram_addr), 32'h01);
    read_chk(5'd0, 8'h33, "post_rst_buf0");
    read_chk(5'd16, 8'h20, "post_rst_buf16");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
